// File: rtl/div_seq.sv
// div_seq: iterative restoring divider, one quotient bit per clock.
// Operands enter on in_valid/in_ready; results leave on out_valid/out_ready.
// A zero divisor finishes in one cycle with quotient=all ones, remainder=dividend.
// Optional feature macro: DIV_SIGNED_EN adds the signed_op port (two's-complement mode).
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   operand handshake (in_ready high only in IDLE)
//   dividend, divisor    operands (WIDTH bits)
//   signed_op            signed mode select, sampled on accept (DIV_SIGNED_EN only)
//   out_valid, out_ready result handshake
//   quotient, remainder  results (WIDTH bits), held until next result
//   div_by_zero          result came from a zero divisor
module div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
    input  logic             signed_op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_quo_q;
    logic             neg_rem_q;

    logic             accept;
    logic             divisor_zero;
    logic             last_iter;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    logic             out_valid_nxt;
    logic [WIDTH-1:0] quotient_nxt;
    logic [WIDTH-1:0] remainder_nxt;
    logic             div_by_zero_nxt;

    // Operand magnitudes and result-sign flags captured on accept
`ifdef DIV_SIGNED_EN
    assign a_neg = signed_op & dividend[WIDTH-1];
    assign b_neg = signed_op & divisor[WIDTH-1];
    assign a_mag = a_neg ? WIDTH'(-dividend) : dividend;
    assign b_mag = b_neg ? WIDTH'(-divisor) : divisor;
`else
    assign a_neg = 1'b0;
    assign b_neg = 1'b0;
    assign a_mag = dividend;
    assign b_mag = divisor;
`endif

    assign divisor_zero = (divisor == '0);
    assign accept       = in_valid && (state == IDLE);
    assign last_iter    = (cnt_q == CNT_W'(1));

    // One restoring step: shift in next dividend bit, keep difference when no borrow.
    // Since rem_q < dvs_q, a negative difference always shows up in bit WIDTH.
    assign trial = {rem_q, quo_q[WIDTH-1]};
    assign diff  = trial - {1'b0, dvs_q};

    always_comb begin
        rem_step = trial[WIDTH-1:0];
        quo_step = {quo_q[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
            rem_step = diff[WIDTH-1:0];
            quo_step = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

    // Most-negative / -1 wraps back to most-negative naturally here
    assign quo_fix = neg_quo_q ? WIDTH'(-quo_step) : quo_step;
    assign rem_fix = neg_rem_q ? WIDTH'(-rem_step) : rem_step;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = divisor_zero ? DONE : BUSY;
            BUSY:    if (last_iter) state_nxt = DONE;
            DONE:    if (out_valid && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: in_ready straight from state, next values for registered results
    always_comb begin
        in_ready        = (state == IDLE);
        out_valid_nxt   = (state_nxt == DONE);
        quotient_nxt    = quotient;
        remainder_nxt   = remainder;
        div_by_zero_nxt = div_by_zero;
        if (accept && divisor_zero) begin
            quotient_nxt    = '1;
            remainder_nxt   = dividend;
            div_by_zero_nxt = 1'b1;
        end else if ((state == BUSY) && last_iter) begin
            quotient_nxt    = quo_fix;
            remainder_nxt   = rem_fix;
            div_by_zero_nxt = 1'b0;
        end
    end

    // Iteration datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (accept) begin
            rem_q     <= '0;
            quo_q     <= a_mag;
            dvs_q     <= b_mag;
            cnt_q     <= CNT_W'(WIDTH);
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
        end else if (state == BUSY) begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            out_valid   <= out_valid_nxt;
            quotient    <= quotient_nxt;
            remainder   <= remainder_nxt;
            div_by_zero <= div_by_zero_nxt;
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed bench for div_seq with an expected-result queue.
module tb_div_seq;
    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
`ifdef DIV_SIGNED_EN
    logic         signed_op;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    div_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef DIV_SIGNED_EN
        .signed_op   (signed_op),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, want);
        end
    endtask

    // Reference: language division, with zero-divisor and signed-overflow results fixed
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
        exp_t e;
        e.dbz = 1'b0;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else if (s) begin
            if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
                e.q = a;
                e.r = '0;
            end else begin
                e.q = W'($signed(a) / $signed(b));
                e.r = W'($signed(a) % $signed(b));
            end
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Called at a negedge; returns at the negedge right after the accept edge
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
        int n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", W'(in_ready), W'(1));
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
`ifdef DIV_SIGNED_EN
        signed_op = s;
`endif
        sb.push_back(model(a, b, s));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits for out_valid, checks latency (rising edges from accept edge) and result
    task automatic receive(input string tag, input int want_lat, input bit handshake);
        int   lat = 1;
        exp_t e;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, W'(lat), W'(want_lat));
        chk({tag, "_in_ready_done"}, W'(in_ready), W'(0));
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_q"}, quotient, e.q);
            chk({tag, "_r"}, remainder, e.r);
            chk({tag, "_dbz"}, W'(div_by_zero), W'(e.dbz));
        end
        if (handshake) begin
            out_ready = 1'b1;
            @(negedge clk);
            chk({tag, "_valid_drop"}, W'(out_valid), W'(0));
            chk({tag, "_ready_rise"}, W'(in_ready), W'(1));
        end
    endtask

    initial begin
        bit seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
`ifdef DIV_SIGNED_EN
        signed_op = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_quotient", quotient, W'(0));
        chk("rst_remainder", remainder, W'(0));
        chk("rst_dbz", W'(div_by_zero), W'(0));
        rst_n = 1'b1;
        @(negedge clk);

        send(32'd100, 32'd7, 1'b0);
        receive("u100_7", 33, 1'b1);

        send(32'h1234_5678, 32'd0, 1'b0);
        receive("zero_div", 1, 1'b1);

        // Backpressure: hold result for 10 cycles
        out_ready = 1'b0;
        send(32'hFFFF_FFFF, 32'd1, 1'b0);
        receive("bp", 33, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", W'(out_valid), W'(1));
            chk("bp_in_ready", W'(in_ready), W'(0));
            chk("bp_q", quotient, 32'hFFFF_FFFF);
            chk("bp_r", remainder, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_drop", W'(out_valid), W'(0));
        chk("bp_ready_rise", W'(in_ready), W'(1));

        // Boundary operands
        send(32'd5, 32'd9, 1'b0);
        receive("small", 33, 1'b1);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        receive("max_max", 33, 1'b1);
        send(32'h8000_0000, 32'd3, 1'b0);
        receive("msb_3", 33, 1'b1);
        send(32'hFFFF_FFF9, 32'd2, 1'b0);
        receive("big_2", 33, 1'b1);
        for (int i = 0; i < 3; i++) begin
            send($urandom(), W'($urandom_range(1, 65535)), 1'b0);
            receive("rand", 33, 1'b1);
        end

        // in_valid held through BUSY with changed operands
        in_valid = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd10;
        sb.push_back(model(32'd1000, 32'd10, 1'b0));
        @(negedge clk);
        dividend = 32'd77;
        divisor  = 32'd5;
        receive("held_a", 33, 1'b1);
        sb.push_back(model(32'd77, 32'd5, 1'b0));
        @(negedge clk);
        in_valid = 1'b0;
        receive("held_b", 33, 1'b1);

        // Asynchronous reset in the middle of BUSY
        send(32'd50000, 32'd3, 1'b0);
        repeat (13) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", W'(in_ready), W'(1));
        chk("arst_out_valid", W'(out_valid), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_rel_valid", W'(out_valid), W'(0));
        chk("arst_rel_ready", W'(in_ready), W'(1));
        if (sb.size() != 0) void'(sb.pop_front());
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        chk("arst_no_stale", W'(seen), W'(0));
        send(32'd9, 32'd3, 1'b0);
        receive("after_rst", 33, 1'b1);

`ifdef DIV_SIGNED_EN
        send(32'hFFFF_FFF9, 32'd2, 1'b1);
        receive("s_m7_2", 33, 1'b1);
        chk("s_m7_2_q_const", quotient, 32'hFFFF_FFFD);
        send(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        receive("s_ovf", 33, 1'b1);
        chk("s_ovf_q_const", quotient, 32'h8000_0000);
        send(32'd7, 32'hFFFF_FFFE, 1'b1);
        receive("s_7_m2", 33, 1'b1);
        send(32'hFFFF_FFF9, 32'd0, 1'b1);
        receive("s_zero", 1, 1'b1);
        send(32'hFFFF_FFF9, 32'd2, 1'b0);
        receive("s_off", 33, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Iterative 32-bit restoring divider for the ALU datapath.
- Produces quotient and remainder one bit per cycle using compare/subtract.
- Sits beside the combinational ALU ops. Operands enter on a valid/ready handshake; results leave on a second valid/ready handshake.
- Zero-divisor and overflow results are fixed so the ALU result mux needs no special casing.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥2.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  divider can accept operands.
- dividend  in  WIDTH  numerator.
- divisor  in  WIDTH  denominator.
- signed_op  in  1  treat operands as two's complement (present only with DIV_SIGNED_EN).
- out_valid  out  1  result held valid.
- out_ready  in  1  consumer takes result.
- quotient  out  WIDTH  quotient.
- remainder  out  WIDTH  remainder.
- div_by_zero  out  1  result came from a zero divisor.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE; out_valid=0; quotient=0; remainder=0; div_by_zero=0; counter=0.
- Reset mid-operation abandons the operation with no output.
- States:
  - IDLE -> BUSY on in_valid&in_ready when divisor≠0.
  - IDLE -> DONE on in_valid&in_ready when divisor=0.
  - BUSY -> DONE after WIDTH iterations.
  - DONE -> IDLE on out_valid&out_ready.
- in_ready = (state==IDLE), combinational from state only. No accept in BUSY or DONE.
- Accept cycle: latch magnitudes. In signed mode, negate negative operands. Also latch result-sign flags. Clear the partial remainder and load counter=WIDTH.
- BUSY, each cycle:
  - Form the trial value: shift {rem, quo} left by 1, bringing in the next dividend bit MSB-first. Subtract the divisor from the upper part.
  - If the difference is non-negative (no borrow, checked at WIDTH+1 bits), keep it and set the quotient bit to 1. Otherwise restore and set the quotient bit to 0.
  - Decrement the counter.
- Last iteration: on counter 1->0, apply sign correction and register the outputs.
- Latency: out_valid rises WIDTH+1 cycles after the accept edge. For WIDTH=32 that is 33 cycles, independent of operand values.
- Zero divisor: out_valid 1 cycle after accept. quotient = all ones; remainder = dividend (unmodified, either mode); div_by_zero=1.
- Signed overflow (dividend = most-negative, divisor = -1): normal 33-cycle path. quotient = most-negative (0x80000000); remainder = 0; div_by_zero=0.
- Signed rounding:
  - Quotient truncates toward zero; negate it when the operand signs differ.
  - Remainder takes the dividend's sign.
  - quotient*divisor+remainder == dividend always holds for nonzero divisors.
- DONE: outputs stable while out_valid=1 and out_ready=0, for any number of cycles.
- Handshake: out_valid falls the cycle after out_valid&out_ready. in_ready rises in that same cycle. Minimum gap between back-to-back accepts is therefore WIDTH+2 cycles.
- quotient, remainder and div_by_zero keep their last values in IDLE. They are only meaningful while out_valid=1.
- Simultaneous events: in_valid held high during BUSY/DONE is ignored, with no operand capture. out_ready high with out_valid low has no effect.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined: signed_op port exists. signed_op=1 selects two's-complement behaviour as above; signed_op=0 selects unsigned. signed_op is sampled only on the accept cycle.
- Undefined: no signed_op port and no negation logic; operands are always unsigned.
- Zero-divisor behaviour is identical in both builds.

Test Plan:
- Unsigned 100/7, out_ready=1 -> out_valid exactly 33 cycles after accept; quotient=14, remainder=2, div_by_zero=0.
- Divisor 0, dividend 0x12345678 -> out_valid 1 cycle after accept; quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1.
- DIV_SIGNED_EN, signed -7/2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
- Backpressure: 0xFFFFFFFF/1 with out_ready=0 for 10 cycles after out_valid -> outputs stable (quotient=0xFFFFFFFF, remainder=0), in_ready=0 throughout. After the handshake, in_ready=1 the next cycle.
- in_valid held high with new operands during BUSY -> the first result is unaffected; the second operation is accepted only when in_ready rises.
- Assert rst_n=0 asynchronously mid-BUSY (cycle 15) -> out_valid=0 and in_ready=1 immediately after release; no stale result ever appears. A following 9/3 returns quotient=3, remainder=0.
